// File: rtl/riscv_trace_classifier_if.sv
// Bus bundle for the retire-trace classifier: table programming, the retire feed,
// the trace FIFO valid/ready head, counter readback and drop statistics.
interface riscv_trace_classifier_if #(
  parameter int unsigned NUM_CLASSES = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DROP_W      = 16
);
  localparam int unsigned CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              cfg_we;
  logic [CLS_W-1:0]  cfg_idx;
  logic [31:0]       cfg_mask;
  logic [31:0]       cfg_match;
  logic              cfg_en;
  logic              filter_en;
  logic              retire_valid;
  logic [31:0]       retire_pc;
  logic [31:0]       retire_instr;
  logic              trace_valid;
  logic              trace_ready;
  logic [31:0]       trace_pc;
  logic [31:0]       trace_instr;
  logic [CLS_W-1:0]  trace_class;
  logic              trace_hit;
  logic [LVL_W-1:0]  fifo_level;
  logic [CLS_W-1:0]  cnt_rd_idx;
  logic [CNT_W-1:0]  cnt_rd_data;
  logic              cnt_clr;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output cfg_we, cfg_idx, cfg_mask, cfg_match, cfg_en, filter_en,
    output retire_valid, retire_pc, retire_instr, trace_ready, cnt_rd_idx, cnt_clr,
    input  trace_valid, trace_pc, trace_instr, trace_class, trace_hit, fifo_level,
    input  cnt_rd_data, drop_cnt
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_mask, cfg_match, cfg_en, filter_en,
    input  retire_valid, retire_pc, retire_instr, trace_ready, cnt_rd_idx, cnt_clr,
    output trace_valid, trace_pc, trace_instr, trace_class, trace_hit, fifo_level,
    output cnt_rd_data, drop_cnt
  );
endinterface

// File: rtl/riscv_trace_classifier.sv
// Classifies retired instructions against a programmable mask/match table, counts
// per-class hits and queues tagged trace records for a valid/ready consumer.
module riscv_trace_classifier #(
  parameter int unsigned NUM_CLASSES = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DROP_W      = 16
) (
  input logic                     clk,
  input logic                     rst,
  riscv_trace_classifier_if.slave bus
);
  localparam int unsigned CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  CntMax  = '1;
  localparam logic [DROP_W-1:0] DropMax = '1;

  logic [31:0]       mask_q  [NUM_CLASSES];
  logic [31:0]       match_q [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] en_q;
  logic [CNT_W-1:0]  cnt_q   [NUM_CLASSES];
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [31:0]       fifo_pc_q    [DEPTH];
  logic [31:0]       fifo_instr_q [DEPTH];
  logic [CLS_W-1:0]  fifo_cls_q   [DEPTH];
  logic              fifo_hit_q   [DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
  logic [PTR_W-1:0]  wr_idx, rd_idx;

  logic             hit;
  logic [CLS_W-1:0] cls;
  logic             empty, full, push_req, pop, push, drop;

  // Walk from the top so the lowest-index hit is the one left standing.
  always_comb begin
    hit = 1'b0;
    cls = '0;
    for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
      if (en_q[i] && ((bus.retire_instr & mask_q[i]) == match_q[i])) begin
        hit = 1'b1;
        cls = CLS_W'(i);
      end
    end
  end

  assign level    = wr_ptr_q - rd_ptr_q;
  assign wr_idx   = wr_ptr_q[PTR_W-1:0];
  assign rd_idx   = rd_ptr_q[PTR_W-1:0];
  assign empty    = (level == '0);
  assign full     = (level == (PTR_W + 1)'(DEPTH));
  assign push_req = bus.retire_valid && (!bus.filter_en || hit);
  assign pop      = !empty && bus.trace_ready;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (drop && (drop_q != DropMax)) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_pc_q[wr_idx]    <= bus.retire_pc;
      fifo_instr_q[wr_idx] <= bus.retire_instr;
      fifo_cls_q[wr_idx]   <= cls;
      fifo_hit_q[wr_idx]   <= hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) begin
        mask_q[i]  <= '0;
        match_q[i] <= '0;
      end
      en_q <= '0;
    end else if (bus.cfg_we && (32'(bus.cfg_idx) < NUM_CLASSES)) begin
      mask_q[bus.cfg_idx]  <= bus.cfg_mask;
      match_q[bus.cfg_idx] <= bus.cfg_match;
      en_q[bus.cfg_idx]    <= bus.cfg_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
    end else if (bus.retire_valid && hit && (cnt_q[cls] != CntMax)) begin
      cnt_q[cls] <= cnt_q[cls] + 1'b1;
    end
  end

  assign bus.trace_valid = !empty;
  assign bus.trace_pc    = empty ? '0 : fifo_pc_q[rd_idx];
  assign bus.trace_instr = empty ? '0 : fifo_instr_q[rd_idx];
  assign bus.trace_class = empty ? '0 : fifo_cls_q[rd_idx];
  assign bus.trace_hit   = empty ? 1'b0 : fifo_hit_q[rd_idx];
  assign bus.fifo_level  = level;
  assign bus.drop_cnt    = drop_q;
  assign bus.cnt_rd_data = (32'(bus.cnt_rd_idx) < NUM_CLASSES) ? cnt_q[bus.cnt_rd_idx] : '0;
endmodule

// File: tb/tb_riscv_trace_classifier.sv
// Bench for riscv_trace_classifier: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_riscv_trace_classifier;
  localparam int unsigned NC     = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DROP_W = 16;
  localparam int unsigned CMAX   = (1 << CNT_W) - 1;
  localparam int unsigned DMAX   = (1 << DROP_W) - 1;
  localparam logic [31:0] ADDI   = 32'h0050_0093;
  localparam logic [31:0] ADD    = 32'h0000_0033;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_trace_classifier_if #(.NUM_CLASSES(NC), .DEPTH(DEPTH), .CNT_W(CNT_W), .DROP_W(DROP_W))
    bus ();

  riscv_trace_classifier #(.NUM_CLASSES(NC), .DEPTH(DEPTH), .CNT_W(CNT_W), .DROP_W(DROP_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  cls;
    logic        hit;
  } rec_t;

  logic [31:0] m_mask [NC];
  logic [31:0] m_match[NC];
  bit          m_en   [NC];
  int unsigned m_cnt  [NC];
  int unsigned m_drop;
  rec_t        m_q[$];

  function automatic void classify(input logic [31:0] instr, output bit h, output int c);
    h = 0;
    c = 0;
    for (int i = 0; i < NC; i++) begin
      if (m_en[i] && ((instr & m_mask[i]) == m_match[i])) begin
        h = 1;
        c = i;
        break;
      end
    end
  endfunction

  always @(posedge clk) begin
    bit   h;
    int   c;
    rec_t r;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        m_mask[i] = '0; m_match[i] = '0; m_en[i] = 0; m_cnt[i] = 0;
      end
      m_drop = 0;
      m_q.delete();
    end else begin
      classify(bus.retire_instr, h, c);
      if (m_q.size() > 0 && bus.trace_ready) void'(m_q.pop_front());
      if (bus.retire_valid && (!bus.filter_en || h)) begin
        r.pc = bus.retire_pc; r.instr = bus.retire_instr; r.cls = 8'(c); r.hit = h;
        if (m_q.size() < DEPTH) m_q.push_back(r);
        else if (m_drop < DMAX) m_drop++;
      end
      if (bus.cnt_clr) begin
        for (int i = 0; i < NC; i++) m_cnt[i] = 0;
      end else if (bus.retire_valid && h && m_cnt[c] < CMAX) begin
        m_cnt[c]++;
      end
      if (bus.cfg_we) begin
        m_mask[bus.cfg_idx]  = bus.cfg_mask;
        m_match[bus.cfg_idx] = bus.cfg_match;
        m_en[bus.cfg_idx]    = bus.cfg_en;
      end
    end
  end

  // Stimulus changes 2 time units after posedge, so the falling edge sees settled outputs.
  always @(negedge clk) begin
    rec_t hd;
    hd = '0;
    if (m_q.size() > 0) hd = m_q[0];
    check("valid", 64'(bus.trace_valid), 64'(m_q.size() > 0));
    check("pc",    64'(bus.trace_pc),    64'(hd.pc));
    check("instr", 64'(bus.trace_instr), 64'(hd.instr));
    check("class", 64'(bus.trace_class), 64'(hd.cls));
    check("hit",   64'(bus.trace_hit),   64'(hd.hit));
    check("level", 64'(bus.fifo_level),  64'(m_q.size()));
    check("drop",  64'(bus.drop_cnt),    64'(m_drop));
    check("cnt",   64'(bus.cnt_rd_data), 64'(m_cnt[bus.cnt_rd_idx]));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_entry(input int idx, input logic [31:0] mask, input logic [31:0] match,
                           input bit en);
    bus.cfg_we = 1'b1; bus.cfg_idx = 3'(idx); bus.cfg_mask = mask;
    bus.cfg_match = match; bus.cfg_en = en;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr);
    bus.retire_valid = 1'b1; bus.retire_pc = pc; bus.retire_instr = instr;
    tick();
    bus.retire_valid = 1'b0;
  endtask

  task automatic lit_cnt(input string name, input int idx, input int exp);
    bus.cnt_rd_idx = 3'(idx);
    #1;
    check(name, 64'(bus.cnt_rd_data), 64'(exp));
  endtask

  task automatic drain();
    bus.trace_ready = 1'b1;
    repeat (DEPTH + 1) tick();
    bus.trace_ready = 1'b0;
  endtask

  initial begin
    bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_mask = '0; bus.cfg_match = '0; bus.cfg_en = 0;
    bus.filter_en = 0; bus.retire_valid = 0; bus.retire_pc = '0; bus.retire_instr = '0;
    bus.trace_ready = 0; bus.cnt_rd_idx = '0; bus.cnt_clr = 0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_valid", 64'(bus.trace_valid), 64'd0);
    check("rst_level", 64'(bus.fifo_level), 64'd0);
    check("rst_drop", 64'(bus.drop_cnt), 64'd0);
    lit_cnt("rst_cnt0", 0, 0);

    // 1: addi hits entry 0, visible next cycle
    set_entry(0, 32'h0000_707F, 32'h0000_0013, 1);
    retire(32'h1000, ADDI);
    check("t1_valid", 64'(bus.trace_valid), 64'd1);
    check("t1_pc", 64'(bus.trace_pc), 64'h1000);
    check("t1_instr", 64'(bus.trace_instr), 64'(ADDI));
    check("t1_hit", 64'(bus.trace_hit), 64'd1);
    check("t1_class", 64'(bus.trace_class), 64'd0);
    lit_cnt("t1_cnt0", 0, 1);
    drain();

    // 2: filtered, jal hits class 3, add dropped by filter
    set_entry(3, 32'h0000_007F, 32'h0000_006F, 1);
    bus.filter_en = 1'b1;
    retire(32'h2000, 32'h0080_006F);
    retire(32'h2004, ADD);
    check("t2_level", 64'(bus.fifo_level), 64'd1);
    check("t2_class", 64'(bus.trace_class), 64'd3);
    check("t2_pc", 64'(bus.trace_pc), 64'h2000);
    lit_cnt("t2_cnt3", 3, 1);
    bus.filter_en = 1'b0;
    drain();

    // 3: two catch-alls, lower index wins
    set_entry(5, 32'h0, 32'h0, 1);
    set_entry(2, 32'h0, 32'h0, 1);
    retire(32'h3000, ADD);
    check("t3_class", 64'(bus.trace_class), 64'd2);
    lit_cnt("t3_cnt2", 2, 1);
    lit_cnt("t3_cnt5", 5, 0);
    drain();

    // 4: overflow with ready low, then push+pop while full
    bus.retire_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.retire_pc = 32'h4000 + 32'(4 * i);
      bus.retire_instr = ADD + 32'(i << 7);
      tick();
    end
    bus.retire_valid = 1'b0;
    check("t4_level", 64'(bus.fifo_level), 64'd16);
    check("t4_drop", 64'(bus.drop_cnt), 64'd4);
    check("t4_head", 64'(bus.trace_pc), 64'h4000);
    bus.trace_ready = 1'b1;
    retire(32'h4100, ADD);
    bus.trace_ready = 1'b0;
    check("t4_level_pp", 64'(bus.fifo_level), 64'd16);
    check("t4_drop_pp", 64'(bus.drop_cnt), 64'd4);
    check("t4_head_pp", 64'(bus.trace_pc), 64'h4004);
    drain();
    check("t4_empty", 64'(bus.fifo_level), 64'd0);

    // 5: counter saturation and clear priority
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    lit_cnt("t5_clr", 0, 0);
    bus.trace_ready = 1'b1;
    repeat (CMAX - 1) retire(32'h4800, ADDI);
    lit_cnt("t5_cnt14", 0, CMAX - 1);
    repeat (3) retire(32'h4800, ADDI);
    lit_cnt("t5_sat", 0, CMAX);
    bus.cnt_clr = 1'b1;
    retire(32'h4800, ADDI);
    bus.cnt_clr = 1'b0;
    lit_cnt("t5_clr_hit", 0, 0);
    drain();

    // 6: same-cycle table write uses the old entry
    set_entry(2, 32'h0, 32'h0, 0);
    set_entry(3, 32'h0, 32'h0, 0);
    set_entry(5, 32'h0, 32'h0, 0);
    bus.cfg_we = 1'b1; bus.cfg_idx = 3'd0; bus.cfg_mask = 32'h707F;
    bus.cfg_match = 32'h13; bus.cfg_en = 1'b0;
    retire(32'h5000, ADDI);
    bus.cfg_we = 1'b0;
    retire(32'h5004, ADDI);
    check("t6_level", 64'(bus.fifo_level), 64'd2);
    check("t6_hit_old", 64'(bus.trace_hit), 64'd1);
    check("t6_class_old", 64'(bus.trace_class), 64'd0);
    bus.trace_ready = 1'b1;
    tick();
    bus.trace_ready = 1'b0;
    check("t6_pc_new", 64'(bus.trace_pc), 64'h5004);
    check("t6_hit_new", 64'(bus.trace_hit), 64'd0);
    for (int i = 0; i < 4; i++) retire(32'h6000 + 32'(4 * i), ADD);
    check("t6_level5", 64'(bus.fifo_level), 64'd5);
    rst = 1'b1;
    bus.retire_valid = 1'b1; bus.retire_instr = ADDI;
    tick();
    bus.retire_valid = 1'b0;
    check("t6_rst_valid", 64'(bus.trace_valid), 64'd0);
    check("t6_rst_level", 64'(bus.fifo_level), 64'd0);
    for (int i = 0; i < NC; i++) lit_cnt("t6_rst_cnt", i, 0);
    rst = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
